// File: rtl/submod_drain_pkg.sv
// submod_drain_pkg: shared state encoding and parameter legality check for submod_drain.
package submod_drain_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
    function automatic bit const_legal(longint unsigned step, int unsigned width);
        return step != 0 && (width >= 64 || step < (64'd1 << width));
    endfunction
endpackage

// File: rtl/submod_drain_if.sv
// submod_drain_if: load/out handshake bundle plus status flags.
interface submod_drain_if #(parameter int unsigned WIDTH = 8);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             busy;
    logic             done;
    modport master (output load_valid, load_value, out_ready,
                    input  load_ready, out_valid, out_value, busy, done);
    modport slave  (input  load_valid, load_value, out_ready,
                    output load_ready, out_valid, out_value, busy, done);
endinterface

// File: rtl/submod_drain_step.sv
// drain_step: one decrement step of the accumulator and the final-beat flag.
module drain_step #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SOME_CONSTANT = 6
) (
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] next_acc,
    output logic             last
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(SOME_CONSTANT);
    // last guards the subtraction, so next_acc is only used when it cannot underflow
    assign last     = acc <= STEP;
    assign next_acc = acc - STEP;
endmodule

// File: rtl/submod_drain.sv
// submod_drain: loads a value and streams it out, stepping down by SOME_CONSTANT per accepted beat.
module submod_drain
    import submod_drain_pkg::*;
#(
    parameter int unsigned SOME_CONSTANT = 6,
    parameter int unsigned WIDTH         = 8
) (
    input logic           clock,
    input logic           reset_n,
    submod_drain_if.slave bus
);
    if (!const_legal(longint'(SOME_CONSTANT), WIDTH)) begin : g_bad_const
        $error("submod_drain: SOME_CONSTANT must be nonzero and below 2**WIDTH");
    end
    state_t           state, state_next;
    logic [WIDTH-1:0] acc, next_acc;
    logic             last, load_fire, beat_fire;
    drain_step #(.WIDTH(WIDTH), .SOME_CONSTANT(SOME_CONSTANT)) u_step (
        .acc     (acc),
        .next_acc(next_acc),
        .last    (last)
    );
    assign load_fire = bus.load_valid && bus.load_ready;
    assign beat_fire = bus.out_valid && bus.out_ready;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            if (load_fire) acc <= bus.load_value;
            else if (beat_fire && !last) acc <= next_acc;
            else if (state == DONE) acc <= '0;
        end
    end
    always_comb begin
        state_next = (state == IDLE)  ? (load_fire ? DRAIN : IDLE) :
                     (state == DRAIN) ? ((beat_fire && last) ? DONE : DRAIN) :
                                        IDLE;
    end
    always_comb begin
        bus.load_ready = state == IDLE;
        bus.out_valid  = state == DRAIN;
        bus.busy       = state != IDLE;
        bus.done       = state == DONE;
        bus.out_value  = acc;
    end
endmodule

// File: tb/tb_submod_drain.sv
// tb_submod_drain: default and SOME_CONSTANT=99 instances driven in parallel against a beat-list model.
module tb_submod_drain;
    localparam int unsigned W  = 8;
    localparam int unsigned CA = 6;
    localparam int unsigned CB = 99;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         lv = 1'b0;
    logic [W-1:0] lval = '0;
    logic         ordy = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;
    int unsigned  cst [2];
    int unsigned  mb [2][64];
    int           mh [2];
    int           mn [2];
    bit           md [2];
    int unsigned  exp20 [4];
    always #5 clock = ~clock;
    submod_drain_if #(.WIDTH(W)) ia ();
    submod_drain_if #(.WIDTH(W)) ib ();
    assign ia.load_valid = lv;
    assign ia.load_value = lval;
    assign ia.out_ready  = ordy;
    assign ib.load_valid = lv;
    assign ib.load_value = lval;
    assign ib.out_ready  = ordy;
    submod_drain #(.WIDTH(W)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia));
    submod_drain #(.SOME_CONSTANT(CB), .WIDTH(W)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // The model keeps the full list of beats a load will produce, computed up front.
    function automatic void model_load(input int d, input int unsigned v);
        int unsigned x = v;
        bit fin;
        mh[d] = 0;
        mn[d] = 0;
        do begin
            mb[d][mn[d]] = x;
            mn[d]++;
            fin = x <= cst[d];
            x = x - cst[d];
        end while (!fin);
    endfunction

    function automatic void model_edge(input int d);
        bit pend = mh[d] < mn[d];
        if (!pend && !md[d] && lv) model_load(d, int'(lval));
        else if (pend && ordy) begin
            mh[d]++;
            md[d] = mh[d] == mn[d];
        end else if (md[d]) md[d] = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0;
            mn[d] = 0;
            md[d] = 1'b0;
        end
    endfunction

    task automatic check_dut(input int d);
        bit pend = mh[d] < mn[d];
        string p = d ? "b" : "a";
        chk({p, " out_valid"},  d ? ib.out_valid  : ia.out_valid,  32'(pend));
        chk({p, " load_ready"}, d ? ib.load_ready : ia.load_ready, 32'(!pend && !md[d]));
        chk({p, " busy"},       d ? ib.busy       : ia.busy,       32'(pend || md[d]));
        chk({p, " done"},       d ? ib.done       : ia.done,       32'(md[d]));
        if (pend) chk({p, " out_value"}, d ? ib.out_value : ia.out_value, mb[d][mh[d]]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " a out_valid"},  ia.out_valid,  0);
        chk({tag, " a busy"},       ia.busy,       0);
        chk({tag, " a load_ready"}, ia.load_ready, 1);
        chk({tag, " a done"},       ia.done,       0);
        chk({tag, " a out_value"},  ia.out_value,  0);
        chk({tag, " b out_valid"},  ib.out_valid,  0);
        chk({tag, " b done"},       ib.done,       0);
        chk({tag, " b out_value"},  ib.out_value,  0);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && !(ia.load_ready && ib.load_ready); i++) tick();
        chk("settle idle", 32'(ia.load_ready && ib.load_ready), 1);
    endtask

    task automatic load(input int unsigned v);
        lv   = 1'b1;
        lval = W'(v);
        tick();
        lv   = 1'b0;
    endtask

    initial begin
        cst[0] = CA;
        cst[1] = CB;
        exp20[0] = 20; exp20[1] = 14; exp20[2] = 8; exp20[3] = 2;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        // Load 20 with out_ready held: 20,14,8,2 then done, then idle
        ordy = 1'b1;
        load(20);
        for (int i = 0; i < 4; i++) begin
            chk("a beat20", ia.out_value, exp20[i]);
            tick();
        end
        chk("a done after 2", ia.done, 1);
        tick();
        chk("a idle after done", ia.load_ready, 1);
        settle();
        // Single-beat boundaries: load == SOME_CONSTANT and load 0
        load(6);
        chk("a beat6", ia.out_value, 6);
        tick();
        chk("a done6", ia.done, 1);
        settle();
        load(0);
        chk("a beat0", ia.out_value, 0);
        tick();
        chk("a done0", ia.done, 1);
        settle();
        // Back-pressure holds the first beat
        ordy = 1'b0;
        load(20);
        repeat (3) begin
            chk("a hold20", ia.out_value, 20);
            tick();
        end
        chk("a hold20 end", ia.out_value, 20);
        ordy = 1'b1;
        tick();
        chk("a resume14", ia.out_value, 14);
        tick();
        chk("a resume8", ia.out_value, 8);
        tick();
        chk("a resume2", ia.out_value, 2);
        settle();
        // Large step instance
        load(250);
        chk("b beat250", ib.out_value, 250);
        tick();
        chk("b beat151", ib.out_value, 151);
        tick();
        chk("b beat52", ib.out_value, 52);
        tick();
        chk("b done", ib.done, 1);
        settle();
        // Asynchronous reset during the second beat
        load(20);
        tick();
        chk("a second beat", ia.out_value, 14);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("abort");
        repeat (2) tick();
        reset_n = 1'b1;
        load(7);
        chk("a beat7", ia.out_value, 7);
        tick();
        chk("a beat1", ia.out_value, 1);
        tick();
        chk("a done7", ia.done, 1);
        settle();
        // load_valid held high with random back-pressure
        lv = 1'b1;
        for (int i = 0; i < 80; i++) begin
            lval = W'($urandom_range(0, 255));
            ordy = $urandom_range(0, 3) != 0;
            tick();
        end
        // Fully random traffic
        for (int i = 0; i < 400; i++) begin
            lv   = $urandom_range(0, 2) == 0;
            lval = W'($urandom_range(0, 255));
            ordy = $urandom_range(0, 1) == 1;
            tick();
        end
        lv   = 1'b0;
        ordy = 1'b1;
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
